// File: rtl/maze_pkg.sv
// Shared types and constants for the maze search controller.
// Optional step budget is enabled by defining STEP_LIMIT_EN.
package maze_pkg;

  localparam int COORD_W = 4;

  localparam logic [1:0] DIR_YP = 2'b00;
  localparam logic [1:0] DIR_XP = 2'b01;
  localparam logic [1:0] DIR_XM = 2'b10;
  localparam logic [1:0] DIR_YM = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    MARK,
    MOVE,
    CHECK,
    READ,
    BLOCK,
    RETRACT,
    NEXTDIR,
    BACKTRACK,
    REVERSE,
    STREAM,
    DONE,
    FAIL
  } state_t;

endpackage

// File: rtl/maze_if.sv
// Control/status bundle between the maze controller and its datapath.
// master = controller side, slave = datapath/consumer side.
interface maze_if;
  import maze_pkg::*;

  logic start;
  logic run;
  logic D_out;
  logic invalid;
  logic empty;
  logic co;
  logic found;
  logic finished_reading;

  logic init_x;
  logic init_y;
  logic init_stack;
  logic init_checkList;
  logic init_count;
  logic push;
  logic pop;
  logic checkList_push;
  logic read_checkList;
  logic update_state;
  logic go_back;
  logic load_count;
  logic count_en;
  logic rd;
  logic wr;
  logic move_valid;
  logic done;
  logic fail;

  modport master (
    input  start, run, D_out, invalid, empty,
    input  co, found, finished_reading,
    output init_x, init_y, init_stack,
    output init_checkList, init_count,
    output push, pop, checkList_push,
    output read_checkList, update_state,
    output go_back, load_count, count_en,
    output rd, wr, move_valid, done, fail
  );

  modport slave (
    output start, run, D_out, invalid, empty,
    output co, found, finished_reading,
    input  init_x, init_y, init_stack,
    input  init_checkList, init_count,
    input  push, pop, checkList_push,
    input  read_checkList, update_state,
    input  go_back, load_count, count_en,
    input  rd, wr, move_valid, done, fail
  );

endinterface

// File: rtl/maze_step_limiter.sv
// Move-attempt counter; flags when MAX_STEPS attempts have been made.
// Only instantiated when STEP_LIMIT_EN is defined.
module maze_step_limiter #(
  parameter int MAX_STEPS = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_limit
);
  import maze_pkg::*;

  localparam int CW = $clog2(MAX_STEPS + 1);
  localparam logic [CW-1:0] MAXV = CW'(MAX_STEPS);

  logic [CW-1:0] r_cnt;

  // saturates so the flag stays up until the next INIT
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && r_cnt != MAXV) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_limit = (r_cnt == MAXV);

endmodule

// File: rtl/maze_controller.sv
// DFS sequencing FSM for the maze datapath: search, reverse, stream.
// Define STEP_LIMIT_EN to fail after MAX_STEPS move attempts.
module maze_controller #(
  parameter int MAX_STEPS = 1024
) (
  input  logic   clk,
  input  logic   rst,
  maze_if.master bus
);
  import maze_pkg::*;

  state_t r_state;
  state_t w_next;

  logic r_init;
  logic r_wr;
  logic r_step;
  logic r_blk;
  logic r_ret;
  logic r_done;
  logic r_fail;

  logic w_limit;
  logic w_rd_ok;
  logic w_bt;
  logic w_rev;
  logic w_stream;

`ifdef STEP_LIMIT_EN
  maze_step_limiter #(
    .MAX_STEPS(MAX_STEPS)
  ) u_limit (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == INIT),
    .i_inc   (r_state == MOVE),
    .o_limit (w_limit)
  );
`else
  logic w_unused_max;
  assign w_unused_max = (MAX_STEPS > 0);
  assign w_limit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (bus.start) w_next = INIT;
      INIT:
        w_next = MARK;
      MARK:
        if (w_limit)        w_next = FAIL;
        else if (bus.found) w_next = REVERSE;
        else                w_next = MOVE;
      MOVE:
        w_next = CHECK;
      CHECK:
        w_next = bus.invalid ? BLOCK : READ;
      READ:
        w_next = bus.D_out ? BLOCK : MARK;
      BLOCK:
        w_next = RETRACT;
      RETRACT:
        w_next = NEXTDIR;
      NEXTDIR:
        if (w_limit)     w_next = FAIL;
        else if (bus.co) w_next = BACKTRACK;
        else             w_next = MOVE;
      BACKTRACK:
        w_next = bus.empty ? FAIL : NEXTDIR;
      REVERSE:
        if (bus.empty) w_next = STREAM;
      STREAM:
        if (bus.finished_reading) w_next = DONE;
      DONE, FAIL:
        if (bus.start) w_next = INIT;
      default:
        w_next = IDLE;
    endcase
  end

  // pure state decodes are registered against the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_init  <= 1'b0;
      r_wr    <= 1'b0;
      r_step  <= 1'b0;
      r_blk   <= 1'b0;
      r_ret   <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_init  <= (w_next == INIT);
      r_wr    <= (w_next == MARK);
      r_step  <= (w_next == MOVE);
      r_blk   <= (w_next == BLOCK);
      r_ret   <= (w_next == RETRACT);
      r_done  <= (w_next == DONE);
      r_fail  <= (w_next == FAIL);
    end
  end

  assign w_rd_ok  = (r_state == READ) & ~bus.D_out;
  assign w_bt     = (r_state == BACKTRACK) & ~bus.empty;
  assign w_rev    = (r_state == REVERSE) & ~bus.empty;
  assign w_stream = (r_state == STREAM) & bus.run
                  & ~bus.finished_reading;

  assign bus.init_x         = r_init;
  assign bus.init_y         = r_init;
  assign bus.init_stack     = r_init;
  assign bus.init_checkList = r_init;
  assign bus.init_count     = r_init | w_rd_ok;
  assign bus.push           = r_blk | w_rd_ok;
  assign bus.pop            = r_ret | w_bt | w_rev;
  assign bus.checkList_push = w_rev;
  assign bus.read_checkList = w_stream;
  assign bus.move_valid     = w_stream;
  assign bus.update_state   = r_step | r_ret | w_bt;
  assign bus.go_back        = r_ret | w_bt;
  assign bus.load_count     = w_bt;
  assign bus.count_en       = (r_state == NEXTDIR) & ~bus.co
                            & ~w_limit;
  assign bus.rd             = (r_state == CHECK) & ~bus.invalid;
  assign bus.wr             = r_wr;
  assign bus.done           = r_done;
  assign bus.fail           = r_fail;

endmodule
